// File: rtl/fixed_point_divider.sv
// Sequential signed Qm.n fixed-point divider.
// Radix-2 restoring division on magnitudes, saturating on overflow and divide-by-zero.
module fixed_point_divider #(
    parameter  int M = 7,
    parameter  int Q = 8,
    localparam int W = M + Q + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_dividend,
    input  logic [W-1:0] in_divisor,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_quotient,
    output logic         out_overflow,
    output logic         out_div_zero
);

    localparam int N  = W + Q;
    localparam int CW = $clog2(N);

    localparam logic [W-1:0] POS_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] NEG_MIN = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, DIVIDE, DONE} state_t;

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] cnt;
    logic [N-1:0]  dvd;
    logic [N-1:0]  quo;
    logic [W:0]    rem;
    logic [W-1:0]  dsr;
    logic          neg;

    logic [W-1:0]  a_mag;
    logic [W-1:0]  b_mag;
    logic          b_zero;
    logic          last;
    logic [W:0]    rem_sh;
    logic          ge;
    logic [W:0]    rem_nx;
    logic [N-1:0]  quo_nx;
    logic [W-1:0]  q_res;
    logic          q_ovf;

    // Operand magnitudes and one restoring-division step.
    always_comb begin
        a_mag  = in_dividend[W-1] ? (~in_dividend + 1'b1) : in_dividend;
        b_mag  = in_divisor[W-1] ? (~in_divisor + 1'b1) : in_divisor;
        b_zero = (in_divisor == '0);
        last   = (cnt == CW'(N - 1));
        rem_sh = {rem[W-1:0], dvd[N-1]};
        ge     = (rem_sh >= {1'b0, dsr});
        rem_nx = ge ? (rem_sh - {1'b0, dsr}) : rem_sh;
        quo_nx = {quo[N-2:0], ge};
    end

    // Sign application and saturation of the final quotient.
    always_comb begin
        q_res = '0;
        q_ovf = 1'b0;
        if (!neg) begin
            if (quo_nx > N'(POS_MAX)) begin
                q_res = POS_MAX;
                q_ovf = 1'b1;
            end else begin
                q_res = quo_nx[W-1:0];
            end
        end else begin
            if (quo_nx > N'(NEG_MIN)) begin
                q_res = NEG_MIN;
                q_ovf = 1'b1;
            end else begin
                q_res = ~quo_nx[W-1:0] + 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (in_valid) state_nx = b_zero ? DONE : DIVIDE;
            DIVIDE:  if (last) state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Handshake outputs decoded from state.
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // Datapath: operand capture, iteration and result registration.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt          <= '0;
            dvd          <= '0;
            quo          <= '0;
            rem          <= '0;
            dsr          <= '0;
            neg          <= 1'b0;
            out_quotient <= '0;
            out_overflow <= 1'b0;
            out_div_zero <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        neg <= in_dividend[W-1] ^ in_divisor[W-1];
                        dsr <= b_mag;
                        dvd <= {a_mag, {Q{1'b0}}};
                        rem <= '0;
                        quo <= '0;
                        cnt <= '0;
                        if (b_zero) begin
                            out_quotient <= in_dividend[W-1] ? NEG_MIN : POS_MAX;
                            out_div_zero <= 1'b1;
                            out_overflow <= 1'b0;
                        end
                    end
                end
                DIVIDE: begin
                    rem <= rem_nx;
                    quo <= quo_nx;
                    dvd <= dvd << 1;
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        out_quotient <= q_res;
                        out_overflow <= q_ovf;
                        out_div_zero <= 1'b0;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_overflow <= 1'b0;
                        out_div_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/fixed_point_divider.md
Name: fixed_point_divider

Overview:
- Sequential signed fixed-point divider producing quotient = dividend / divisor in the same Qm.n format as its operands.
- Sits downstream of the combinational fixed-point add/subtract/mult functions; supplies the missing divide operation for datapaths that cannot afford a single-cycle divider.
- Uses a radix-2 restoring algorithm on magnitudes with a valid/ready handshake on both sides.
- Saturates on overflow and on divide-by-zero.

Parameters:
- M, 7, number of integer bits, excluding the sign bit.
- Q, 8, number of fractional bits.
- W, M+Q+1, total operand and result width. Derived; do not override.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept an operand pair.
- in_dividend  in  W  signed dividend, two's complement Qm.n.
- in_divisor  in  W  signed divisor, two's complement Qm.n.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_quotient  out  W  signed quotient, Qm.n.
- out_overflow  out  1  quotient saturated because its magnitude was out of range.
- out_div_zero  out  1  divisor was zero; quotient saturated.

Behaviour:
- All state is registered on the rising edge of clk. Reset is synchronous.
- Reset values:
  - state = IDLE, in_ready = 1, out_valid = 0.
  - out_quotient = 0, out_overflow = 0, out_div_zero = 0.
  - Iteration counter and working registers = 0.
- States are IDLE, DIVIDE and DONE.
- in_ready = (state == IDLE) only. No new operand pair is accepted in DONE, even when the result is consumed in the same cycle.
- Acceptance on the edge where in_valid && in_ready:
  - Capture the signs of both operands and their magnitudes; the magnitude of the most negative value, 2^(W-1), is representable.
  - Form a dividend magnitude of W+Q bits: |dividend| << Q.
  - If divisor == 0, go to DONE directly.
  - Otherwise go to DIVIDE with counter = 0.
- DIVIDE, each cycle:
  - Shift the next dividend bit (MSB first) into the partial remainder.
  - If remainder >= |divisor|, subtract |divisor| and shift 1 into the quotient; otherwise shift 0.
  - Run exactly N = W+Q iterations. On the edge that completes iteration N, go to DONE and register the result.
- Latency:
  - out_valid rises N edges after the acceptance edge (24 for the defaults).
  - For a zero divisor, out_valid rises 1 edge after acceptance.
- Result formation, registered when entering DONE:
  - Negate the quotient magnitude if the dividend sign XOR the divisor sign is 1. Truncation is toward zero.
  - A positive result whose magnitude is > 2^(W-1)-1 becomes 0x7F..F with out_overflow = 1.
  - A negative result whose magnitude is > 2^(W-1) becomes 0x80..0 with out_overflow = 1.
  - A zero divisor sets out_div_zero = 1 and out_overflow = 0. The quotient is 0x7F..F if dividend >= 0, else 0x80..0.
  - The remainder is discarded.
- DONE:
  - out_valid = 1. out_quotient and both flags stay stable until out_valid && out_ready.
  - On that edge: out_valid = 0, flags cleared, state = IDLE.
- in_dividend and in_divisor are ignored outside the acceptance edge. Changing them during DIVIDE has no effect.
- rst asserted in any state, including mid-DIVIDE or DONE with the result unconsumed:
  - Return to reset values on that edge; the pending result is lost.
  - in_ready = 1 on the cycle after rst deasserts.
- A zero dividend with a nonzero divisor yields 0 with no flags, after the full N-cycle latency.

Test Plan:
- Defaults (M=7, Q=8, W=16):
  - Stimulus: dividend = 0x0300 (3.0), divisor = 0x0180 (1.5).
  - Required: out_quotient = 0x0200 (2.0), flags = 0, out_valid exactly 24 edges after acceptance, in_ready = 0 throughout.
- Negative result, truncation toward zero:
  - Stimulus: dividend = 0xFF00 (-1.0), divisor = 0x0300 (3.0).
  - Required: out_quotient = 0xFFAB (-85/256), flags = 0.
- Overflow:
  - Stimulus: dividend = 0x6400 (100.0), divisor = 0x0080 (0.5). Required: 0x7FFF with out_overflow = 1.
  - Stimulus: dividend = 0x8000, divisor = 0xFF00 (-1.0). Required: 0x7FFF with out_overflow = 1.
- Divide by zero:
  - Stimulus: dividend = 0xFE00 (-2.0), divisor = 0x0000. Required: out_valid 1 edge after acceptance, out_quotient = 0x8000, out_div_zero = 1, out_overflow = 0.
  - Stimulus: dividend = 0x0000, divisor = 0x0000. Required: out_quotient = 0x7FFF.
- Backpressure:
  - Stimulus: hold out_ready = 0 for 10 cycles after out_valid; toggle in_valid and the operands during that time.
  - Required: out_quotient and flags stable, in_ready = 0, nothing accepted. After a single out_ready pulse, out_valid = 0 and in_ready = 1 on the next cycle.
- Reset mid-operation and back-to-back:
  - Stimulus: assert rst at iteration 10.
  - Required: out_valid = 0 and in_ready = 1 after rst deasserts.
  - Then a new operation (0x0100 / 0x0200) yields 0x0080 with the full 24-edge latency.
